// File: rtl/i2c_master_byte_ctrl.sv
// ---------------------------------------------------------------------------
// i2c_master_byte_ctrl
//
// Byte-level sequencer of the I2C master. Turns the byte commands latched in
// the control register (Start, Stop, Read, Write, Tx_ack + Tx_data) into a
// sequence of single-bit commands for the bit controller. It collects the
// received byte and the slave ACK, and reports completion and lost arbitration.
//
// Parameters
//   NBITS     bits per byte transfer (default 8)
//
// Ports
//   Clk       master clock, rising edge
//   Rst_n     asynchronous active-low reset
//   I2C_en    core enable; low aborts any transfer back to IDLE
//   Start     generate (repeated) START before the byte
//   Stop      generate STOP after the byte, or alone
//   Read      receive a byte from the slave
//   Write     transmit a byte to the slave
//   Tx_ack    ACK bit driven after a read (0 = ACK, 1 = NACK)
//   Tx_data   byte to transmit
//   Rx_data   received byte (shift register contents)
//   Rx_ack    ACK bit sampled from the slave after a write
//   I2C_done  one-cycle pulse when the command completes
//   I2C_al    arbitration-lost pulse (mirrors Bit_al)
//   Bit_cmd   bit command: NOP=0 START=1 STOP=2 WRITE=3 READ=4
//   Bit_txd   bit to drive for WRITE
//   Bit_ack   bit controller finished the current Bit_cmd (one-cycle pulse)
//   Bit_rxd   bit sampled on READ, valid with Bit_ack
//   Bit_al    arbitration lost (one-cycle pulse)
//
// Build option
//   I2C_NACK_AUTOSTOP_EN  when defined, a write that receives a NACK goes to
//                         STOP even without Stop set, and I2C_done pulses
//                         after that STOP completes.
// ---------------------------------------------------------------------------
module i2c_master_byte_ctrl #(
  parameter int NBITS = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             I2C_en,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Read,
  input  logic             Write,
  input  logic             Tx_ack,
  input  logic [NBITS-1:0] Tx_data,
  output logic [NBITS-1:0] Rx_data,
  output logic             Rx_ack,
  output logic             I2C_done,
  output logic             I2C_al,
  output logic [2:0]       Bit_cmd,
  output logic             Bit_txd,
  input  logic             Bit_ack,
  input  logic             Bit_rxd,
  input  logic             Bit_al
);

  localparam int CNT_W = $clog2(NBITS) + 1;

  localparam logic [2:0] CMD_NOP   = 3'd0;
  localparam logic [2:0] CMD_START = 3'd1;
  localparam logic [2:0] CMD_STOP  = 3'd2;
  localparam logic [2:0] CMD_WRITE = 3'd3;
  localparam logic [2:0] CMD_READ  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WRITE,
    S_READ,
    S_ACK,
    S_STOP
  } state_t;

  state_t           state;
  logic [NBITS-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic             rd_xfer;   // current byte is a read: selects ACK direction
  logic             accept;
  logic             cnt_last;
  logic             nack_stop;

  assign I2C_al  = Bit_al;
  assign Rx_data = shreg;

  // Blocking on I2C_done keeps the still-set command bits from being taken
  // a second time while the register block clears them.
  assign accept   = I2C_en & ~I2C_done & (Start | Stop | Read | Write);
  assign cnt_last = (cnt == CNT_W'(1));

`ifdef I2C_NACK_AUTOSTOP_EN
  // A NACK seen in the ACK slot of a write releases the bus by itself.
  assign nack_stop = ~rd_xfer & Bit_rxd;
`else
  assign nack_stop = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= S_IDLE;
      Bit_cmd  <= CMD_NOP;
      Bit_txd  <= 1'b0;
      Rx_ack   <= 1'b0;
      I2C_done <= 1'b0;
      shreg    <= '0;
      cnt      <= '0;
      rd_xfer  <= 1'b0;
    end else begin
      I2C_done <= 1'b0;
      // Lost arbitration or disable abandons the transfer silently; Bit_al
      // takes precedence over a simultaneous Bit_ack.
      if (Bit_al || (!I2C_en && state != S_IDLE)) begin
        state   <= S_IDLE;
        Bit_cmd <= CMD_NOP;
        Bit_txd <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              shreg   <= Tx_data;
              cnt     <= CNT_W'(NBITS);
              rd_xfer <= Read;
              if (Start) begin
                state   <= S_START;
                Bit_cmd <= CMD_START;
                Bit_txd <= 1'b0;
              end else if (Read) begin
                state   <= S_READ;
                Bit_cmd <= CMD_READ;
                Bit_txd <= 1'b0;
              end else if (Write) begin
                state   <= S_WRITE;
                Bit_cmd <= CMD_WRITE;
                Bit_txd <= Tx_data[NBITS-1];
              end else begin
                state   <= S_STOP;
                Bit_cmd <= CMD_STOP;
                Bit_txd <= 1'b0;
              end
            end
          end

          S_START: begin
            if (Bit_ack) begin
              rd_xfer <= Read;
              if (Read) begin
                state   <= S_READ;
                Bit_cmd <= CMD_READ;
                Bit_txd <= 1'b0;
              end else begin
                state   <= S_WRITE;
                Bit_cmd <= CMD_WRITE;
                Bit_txd <= shreg[NBITS-1];
              end
            end
          end

          S_WRITE: begin
            if (Bit_ack) begin
              shreg <= shreg << 1;
              cnt   <= cnt - CNT_W'(1);
              if (cnt_last) begin
                // ACK slot of a write: release SDA and sample the slave.
                state   <= S_ACK;
                Bit_cmd <= CMD_READ;
                Bit_txd <= 1'b0;
              end else begin
                // Next MSB is the bit below the one just sent.
                Bit_txd <= shreg[NBITS-2];
              end
            end
          end

          S_READ: begin
            if (Bit_ack) begin
              shreg <= {shreg[NBITS-2:0], Bit_rxd};
              cnt   <= cnt - CNT_W'(1);
              if (cnt_last) begin
                // ACK slot of a read: the master drives Tx_ack.
                state   <= S_ACK;
                Bit_cmd <= CMD_WRITE;
                Bit_txd <= Tx_ack;
              end
            end
          end

          S_ACK: begin
            if (Bit_ack) begin
              if (!rd_xfer) Rx_ack <= Bit_rxd;
              if (Stop || nack_stop) begin
                state   <= S_STOP;
                Bit_cmd <= CMD_STOP;
                Bit_txd <= 1'b0;
              end else begin
                state    <= S_IDLE;
                Bit_cmd  <= CMD_NOP;
                Bit_txd  <= 1'b0;
                I2C_done <= 1'b1;
              end
            end
          end

          S_STOP: begin
            if (Bit_ack) begin
              state    <= S_IDLE;
              Bit_cmd  <= CMD_NOP;
              Bit_txd  <= 1'b0;
              I2C_done <= 1'b1;
            end
          end

          default: begin
            state   <= S_IDLE;
            Bit_cmd <= CMD_NOP;
            Bit_txd <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
